// File: rtl/nano_sequencer.sv
// Moore microsequencer for a reduced LC-3b datapath: fetch, decode and a small
// set of execute flows, with every control output decoded from the current state.
module nano_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IR,
  input  logic        BEN,
  input  logic        R,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_PC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic        GateSHF,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic        LSHF1,
  output logic        MARMUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        R_W,
  output logic        DATA_SIZE,
  output logic [5:0]  STATE
);

  typedef enum logic [5:0] {
    StBr       = 6'd0,
    StAdd      = 6'd1,
    StAnd      = 6'd5,
    StLdwAddr  = 6'd6,
    StStwAddr  = 6'd7,
    StXor      = 6'd9,
    StJmp      = 6'd12,
    StShf      = 6'd13,
    StLea      = 6'd14,
    StStwWrite = 6'd16,
    StFetch    = 6'd18,
    StBrTaken  = 6'd22,
    StStwData  = 6'd23,
    StLdwRead  = 6'd25,
    StLdwWb    = 6'd27,
    StDecode   = 6'd32,
    StFetchRd  = 6'd33,
    StLoadIr   = 6'd35
  } state_e;

  state_e state_q, state_d;

  // Only the opcode field steers sequencing; operand fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^IR[11:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:    state_d = StFetchRd;
      StFetchRd:  state_d = R ? StLoadIr : StFetchRd;
      StLoadIr:   state_d = StDecode;
      StDecode: begin
        case (IR[15:12])
          4'b0001: state_d = StAdd;
          4'b0101: state_d = StAnd;
          4'b1001: state_d = StXor;
          4'b1101: state_d = StShf;
          4'b1110: state_d = StLea;
          4'b0000: state_d = StBr;
          4'b1100: state_d = StJmp;
          4'b0110: state_d = StLdwAddr;
          4'b0111: state_d = StStwAddr;
          default: state_d = StFetch;
        endcase
      end
      StBr:       state_d = BEN ? StBrTaken : StFetch;
      StLdwAddr:  state_d = StLdwRead;
      StStwAddr:  state_d = StStwData;
      StLdwRead:  state_d = R ? StLdwWb : StLdwRead;
      StStwData:  state_d = StStwWrite;
      StStwWrite: state_d = R ? StFetch : StStwWrite;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_REG     = 1'b0;
    LD_CC      = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    GateSHF    = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    LSHF1      = 1'b0;
    MARMUX     = 1'b0;
    ALUK       = 2'b00;
    MIO_EN     = 1'b0;
    R_W        = 1'b0;
    DATA_SIZE  = 1'b0;
    unique case (state_q)
      StFetch: begin
        LD_MAR = 1'b1;
        GatePC = 1'b1;
        LD_PC  = 1'b1;
      end
      StFetchRd, StLdwRead: begin
        MIO_EN    = 1'b1;
        DATA_SIZE = 1'b1;
        LD_MDR    = 1'b1;
      end
      StLoadIr: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      StDecode: LD_BEN = 1'b1;
      StAdd, StAnd, StXor: begin
        SR1MUX  = 1'b1;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state_q == StAdd) ? 2'b00 : (state_q == StAnd) ? 2'b01 : 2'b10;
      end
      StShf: begin
        SR1MUX  = 1'b1;
        GateSHF = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      StLea: begin
        ADDR2MUX   = 2'b10;
        LSHF1      = 1'b1;
        MARMUX     = 1'b1;
        GateMARMUX = 1'b1;
        LD_REG     = 1'b1;
      end
      StBrTaken: begin
        ADDR2MUX = 2'b10;
        LSHF1    = 1'b1;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      StJmp: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b01;
        LD_PC   = 1'b1;
      end
      StLdwAddr, StStwAddr: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        LSHF1      = 1'b1;
        MARMUX     = 1'b1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      StLdwWb: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      // Store data passes SR (IR[11:9]) through the ALU onto the bus into MDR.
      StStwData: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      StStwWrite: begin
        MIO_EN    = 1'b1;
        R_W       = 1'b1;
        DATA_SIZE = 1'b1;
      end
      default: ;
    endcase
  end

  assign STATE = state_q;

endmodule

// File: doc/nano_sequencer.md
NANO_SEQUENCER -- requirements
Module: nano_sequencer

Interface
REQ-001 SHALL have ports CLK (in, 1, clock), RESET (in, 1, reset); reset RESET, synchronous, active-high.
REQ-002 SHALL have IR (in, 16, current instruction), BEN (in, 1, latched branch enable), R (in, 1, memory ready).
REQ-003 SHALL output 1-bit LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC (register loads).
REQ-004 SHALL output 1-bit GatePC, GateMDR, GateALU, GateMARMUX, GateSHF (bus drivers).
REQ-005 SHALL output PCMUX[1:0] (00 PC+2, 01 BUS, 10 ADDER), DRMUX (0 IR[11:9], 1 R7), SR1MUX (0 IR[11:9], 1 IR[8:6]).
REQ-006 SHALL output ADDR1MUX (0 PC, 1 BaseR), ADDR2MUX[1:0] (00 zero, 01 off6, 10 off9, 11 off11), LSHF1, MARMUX (0 ZEXT IR[7:0]<<1, 1 ADDER).
REQ-007 SHALL output ALUK[1:0] (00 ADD, 01 AND, 10 XOR, 11 PASSA), MIO_EN, R_W (0 read, 1 write), DATA_SIZE (1 word).
REQ-008 SHALL output STATE[5:0], the current state number.

Function
REQ-009 SHALL hold a 6-bit state register updated on rising CLK; all control outputs are a pure function of STATE (Moore); any output not listed for a state is 0.
REQ-010 State 18: LD_MAR, GatePC, LD_PC, PCMUX=00; next 33.
REQ-011 State 33: MIO_EN, DATA_SIZE, LD_MDR; R=1 -> 35, R=0 -> 33 (wait indefinitely).
REQ-012 State 35: GateMDR, LD_IR; next 32.
REQ-013 State 32: LD_BEN; next by IR[15:12]: 0001->1, 0101->5, 1001->9, 1101->13, 1110->14, 0000->0, 1100->12, 0110->6, 0111->7; any other opcode -> 18 (no-op, no register or CC change).
REQ-014 States 1/5/9: SR1MUX=1, DRMUX=0, GateALU, LD_REG, LD_CC, ALUK=00/01/10 respectively; next 18.
REQ-015 State 13: SR1MUX=1, DRMUX=0, GateSHF, LD_REG, LD_CC; next 18.
REQ-016 State 14: ADDR1MUX=0, ADDR2MUX=10, LSHF1, MARMUX=1, GateMARMUX, DRMUX=0, LD_REG; LD_CC=0; next 18.
REQ-017 State 0: no loads; BEN=1 -> 22, BEN=0 -> 18.
REQ-018 State 22: ADDR1MUX=0, ADDR2MUX=10, LSHF1, PCMUX=10, LD_PC; next 18.
REQ-019 State 12: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC; next 18.
REQ-020 States 6 and 7: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, LSHF1, MARMUX=1, GateMARMUX, LD_MAR; next 25 (from 6) or 23 (from 7).
REQ-021 State 25: MIO_EN, DATA_SIZE, LD_MDR; R=1 -> 27, else stay.
REQ-022 State 27: GateMDR, DRMUX=0, LD_REG, LD_CC; next 18.
REQ-023 State 23: SR1MUX=0, ALUK=11, GateALU, LD_MDR, MIO_EN=0; next 16.
REQ-024 State 16: MIO_EN, R_W=1, DATA_SIZE; R=1 -> 18, else stay.
REQ-025 At most one Gate* output SHALL be 1 in any state; R_W=1 only in state 16.
REQ-026 R is sampled only in states 33, 25, 16; IR only in 32; BEN only in 0.
REQ-027 Any unlisted STATE value SHALL go to 18 next cycle with all outputs 0.

Reset
REQ-028 RESET=1 at a rising edge SHALL force STATE=18 next cycle, overriding any transition including memory-wait states; outputs then follow state 18.
REQ-029 RESET held high SHALL keep STATE=18; first transition to 33 occurs on the first edge with RESET=0.

Verification
REQ-030 Reset, release, R=1 always, IR=0x1042 (ADD) -> STATE 18,33,35,32,1,18; LD_REG=LD_CC=1, ALUK=00 in state 1.
REQ-031 Fetch with R=0 for 3 cycles then 1 -> STATE 33 held 4 cycles, MIO_EN=LD_MDR=1 throughout, then 35.
REQ-032 IR=0x0402 (BR) with BEN=0 -> 32,0,18; with BEN=1 -> 32,0,22,18 and LD_PC=1, PCMUX=10 in 22.
REQ-033 IR=0x7283 (STW), R=1 after 2 wait cycles in 16 -> 32,7,23,16,16,16,18; R_W=1 only in 16.
REQ-034 IR=0x6283 (LDW) with RESET asserted while in 25 -> STATE=18 next cycle, LD_REG never asserted.
REQ-035 IR=0xA000 (unsupported opcode) -> 32,18; LD_REG, LD_CC, LD_PC stay 0 in both cycles except LD_PC in 18.
